// File: rtl/eep_sync_ctrl_if.sv
// eep_sync_ctrl_if
//   Bundles the two ports owned by the EEPROM sync sequencer: the EEPROM
//   external load/store port and the byte-wide backing-store request bus.
//   master: the sequencer (drives strobes, addresses, write data)
//   slave : the EEPROM core plus backing-store controller
//   Parameter ADDR_W: backing-store address width.
interface eep_sync_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic [16:0]       ext_load_read_eep_addr;
    logic [7:0]        ext_eep_data_in;
    logic              ext_eep_data_wr;
    logic [7:0]        ext_eep_data_out;
    logic              ext_eep_data_rd;
    logic              ext_eep_data_en;
    logic              bs_req;
    logic              bs_we;
    logic [ADDR_W-1:0] bs_addr;
    logic [7:0]        bs_wdata;
    logic [7:0]        bs_rdata;
    logic              bs_ack;

    modport master (
        output ext_load_read_eep_addr, ext_eep_data_in, ext_eep_data_wr,
        output ext_eep_data_rd, ext_eep_data_en,
        output bs_req, bs_we, bs_addr, bs_wdata,
        input  ext_eep_data_out, bs_rdata, bs_ack
    );

    modport slave (
        input  ext_load_read_eep_addr, ext_eep_data_in, ext_eep_data_wr,
        input  ext_eep_data_rd, ext_eep_data_en,
        input  bs_req, bs_we, bs_addr, bs_wdata,
        output ext_eep_data_out, bs_rdata, bs_ack
    );
endinterface

// File: rtl/eep_sync_ctrl.sv
// eep_sync_ctrl
//   Mirrors the ATmega32U4 EEPROM to and from a byte-wide backing store.
//   Loads the store into EEPROM on load_req (or after reset when the
//   EEP_SYNC_AUTOLOAD_EN macro is defined) and writes EEPROM back to the
//   store once content_modifyed has been quiet for HOLDOFF cycles.
//
//   state | meaning
//   IDLE  | waiting for a pending load or a matured dirty flag
//   L_RD  | backing-store read request for byte idx
//   L_WR  | EEPROM write strobe with the byte just read
//   S_RD  | EEPROM read strobe for byte idx
//   S_CAP | capture EEPROM read data
//   S_WR  | backing-store write request for byte idx
//   FIN   | one-cycle done pulse, then back to IDLE
//
//   Ports:
//     clk, rst          core clock, synchronous active-high reset
//     load_req          single-cycle load request
//     content_modifyed  EEPROM dirty flag from the core
//     bus               EEPROM port + backing-store bus (master side)
//     busy              high outside IDLE
//     load_done         one-cycle pulse at end of a load
//     save_done         one-cycle pulse at end of a save
module eep_sync_ctrl #(
    parameter int EEP_SIZE = 1024,
    parameter int ADDR_W   = 10,
    parameter int HOLDOFF  = 16000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_req,
    input  logic             content_modifyed,
    eep_sync_ctrl_if.master  bus,
    output logic             busy,
    output logic             load_done,
    output logic             save_done
);

`ifdef EEP_SYNC_AUTOLOAD_EN
    localparam logic AUTOLOAD = 1'b1;
`else
    localparam logic AUTOLOAD = 1'b0;
`endif

    localparam int                HOLD_W   = $clog2(HOLDOFF + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(EEP_SIZE - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLDOFF);

    typedef enum logic [2:0] {
        IDLE, L_RD, L_WR, S_RD, S_CAP, S_WR, FIN
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [HOLD_W-1:0] hold;
    logic              dirty;
    logic              load_pend;
    logic              xfer_is_load;
    logic [7:0]        eep_byte;
    logic [7:0]        wdata_q;

    logic start_load, start_save, idx_inc, cap_rd, cap_wr;
    logic req_c, we_c, wr_c, rd_c, ld_done_c, sv_done_c;
    logic cm_eff;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        start_load = 1'b0;
        start_save = 1'b0;
        idx_inc    = 1'b0;
        cap_rd     = 1'b0;
        cap_wr     = 1'b0;
        req_c      = 1'b0;
        we_c       = 1'b0;
        wr_c       = 1'b0;
        rd_c       = 1'b0;
        ld_done_c  = 1'b0;
        sv_done_c  = 1'b0;
        case (state)
            IDLE: begin
                if (load_pend) begin
                    start_load = 1'b1;
                    state_nxt  = L_RD;
                end else if (dirty && hold == '0) begin
                    start_save = 1'b1;
                    state_nxt  = S_RD;
                end
            end
            L_RD: begin
                req_c = 1'b1;
                if (bus.bs_ack) begin
                    cap_rd    = 1'b1;
                    state_nxt = L_WR;
                end
            end
            L_WR: begin
                wr_c = 1'b1;
                if (idx == LAST_IDX) begin
                    state_nxt = FIN;
                end else begin
                    idx_inc   = 1'b1;
                    state_nxt = L_RD;
                end
            end
            S_RD: begin
                rd_c      = 1'b1;
                state_nxt = S_CAP;
            end
            S_CAP: begin
                cap_wr    = 1'b1;
                state_nxt = S_WR;
            end
            S_WR: begin
                req_c = 1'b1;
                we_c  = 1'b1;
                if (bus.bs_ack) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = FIN;
                    end else begin
                        idx_inc   = 1'b1;
                        state_nxt = S_RD;
                    end
                end
            end
            FIN: begin
                ld_done_c = xfer_is_load;
                sv_done_c = ~xfer_is_load;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The load itself rewrites EEPROM, so the core's flag is not trusted then.
    assign cm_eff = content_modifyed && (state != L_RD) && (state != L_WR);

    always_ff @(posedge clk) begin
        if (rst) begin
            idx          <= '0;
            hold         <= '0;
            dirty        <= 1'b0;
            load_pend    <= AUTOLOAD;
            xfer_is_load <= 1'b0;
            eep_byte     <= '0;
            wdata_q      <= '0;
        end else begin
            // A new request wins over consumption so a load_req that lands
            // on the start cycle still queues one further load.
            if (load_req)        load_pend <= 1'b1;
            else if (start_load) load_pend <= 1'b0;

            if (start_load || start_save) idx <= '0;
            else if (idx_inc)             idx <= idx + 1'b1;

            if (start_load)      xfer_is_load <= 1'b1;
            else if (start_save) xfer_is_load <= 1'b0;

            if (cap_rd) eep_byte <= bus.bs_rdata;
            if (cap_wr) wdata_q  <= bus.ext_eep_data_out;

            if (cm_eff) begin
                dirty <= 1'b1;
                hold  <= HOLD_MAX;
            end else if (ld_done_c) begin
                dirty <= 1'b0;
                hold  <= '0;
            end else begin
                if (start_save)   dirty <= 1'b0;
                if (hold != '0)   hold  <= hold - 1'b1;
            end
        end
    end

    assign bus.ext_load_read_eep_addr = 17'(idx);
    assign bus.ext_eep_data_in        = eep_byte;
    assign bus.ext_eep_data_wr        = wr_c;
    assign bus.ext_eep_data_rd        = rd_c;
    assign bus.ext_eep_data_en        = (state != IDLE);
    assign bus.bs_req                 = req_c;
    assign bus.bs_we                  = we_c;
    assign bus.bs_addr                = idx;
    assign bus.bs_wdata               = wdata_q;
    assign busy                       = (state != IDLE);
    assign load_done                  = ld_done_c;
    assign save_done                  = sv_done_c;

endmodule

// File: tb/tb_eep_sync_ctrl.sv
module tb_eep_sync_ctrl;
    localparam int EEP_SIZE = 4;
    localparam int ADDR_W   = 4;
    localparam int HOLDOFF  = 8;

    localparam int EV_EEP_WR = 0;
    localparam int EV_BS_WR  = 1;
    localparam int EV_LDONE  = 2;
    localparam int EV_SDONE  = 3;

    typedef struct {
        int kind;
        int addr;
        int data;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    logic load_req;
    logic content_modifyed;
    logic busy, load_done, save_done;

    eep_sync_ctrl_if #(.ADDR_W(ADDR_W)) bus_if ();

    eep_sync_ctrl #(
        .EEP_SIZE(EEP_SIZE),
        .ADDR_W  (ADDR_W),
        .HOLDOFF (HOLDOFF)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .load_req        (load_req),
        .content_modifyed(content_modifyed),
        .bus             (bus_if),
        .busy            (busy),
        .load_done       (load_done),
        .save_done       (save_done)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    ev_t  exp_q[$];
    logic [7:0] store_mem [EEP_SIZE];
    logic [7:0] eep_mem   [EEP_SIZE];
    int   ack_lat = 2;

    function automatic ev_t mk(input int k, input int a, input int d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Reference model: a load copies the whole store into EEPROM in address
    // order, a save copies the whole EEPROM into the store.
    task automatic expect_load();
        for (int i = 0; i < EEP_SIZE; i++) exp_q.push_back(mk(EV_EEP_WR, i, int'(store_mem[i])));
        exp_q.push_back(mk(EV_LDONE, 0, 0));
    endtask

    task automatic expect_save(input int nbytes, input bit with_done);
        for (int i = 0; i < nbytes; i++) exp_q.push_back(mk(EV_BS_WR, i, int'(eep_mem[i])));
        if (with_done) exp_q.push_back(mk(EV_SDONE, 0, 0));
    endtask

    task automatic randomize_store();
        for (int i = 0; i < EEP_SIZE; i++) store_mem[i] = 8'($urandom);
    endtask

    task automatic core_writes_eeprom();
        for (int i = 0; i < EEP_SIZE; i++) eep_mem[i] = 8'($urandom);
    endtask

    task automatic pulse_cm();
        content_modifyed = 1'b1;
        @(negedge clk);
        content_modifyed = 1'b0;
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic wait_q_empty(input string name, input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        #2;
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_rd_addr(input string name, input int a);
        int n;
        n = 0;
        while (!(bus_if.ext_eep_data_rd && int'(bus_if.ext_load_read_eep_addr) == a) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(bus_if.ext_eep_data_rd), 1);
    endtask

    // EEPROM core and backing-store environment.
    initial begin
        int   cnt;
        logic rd_pend;
        int   rd_addr;
        cnt     = 0;
        rd_pend = 1'b0;
        rd_addr = 0;
        bus_if.bs_ack           = 1'b0;
        bus_if.bs_rdata         = 8'h00;
        bus_if.ext_eep_data_out = 8'h00;
        forever begin
            @(negedge clk);
            if (rd_pend) bus_if.ext_eep_data_out = eep_mem[rd_addr];
            else         bus_if.ext_eep_data_out = 8'($urandom);
            rd_pend = bus_if.ext_eep_data_rd;
            rd_addr = int'(bus_if.ext_load_read_eep_addr);
            if (bus_if.ext_eep_data_wr)
                eep_mem[int'(bus_if.ext_load_read_eep_addr)] = bus_if.ext_eep_data_in;
            if (rst || bus_if.bs_ack) begin
                bus_if.bs_ack = 1'b0;
                cnt = 0;
            end else if (bus_if.bs_req) begin
                cnt++;
                if (cnt >= ack_lat) begin
                    bus_if.bs_ack = 1'b1;
                    if (bus_if.bs_we) store_mem[int'(bus_if.bs_addr)] = bus_if.bs_wdata;
                    else              bus_if.bs_rdata = store_mem[int'(bus_if.bs_addr)];
                end
            end
        end
    end

    task automatic observe(input ev_t got);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event got kind=%0d addr=%0d data=%0h exp none",
                     got.kind, got.addr, got.data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != got.kind || e.addr != got.addr || e.data != got.data) begin
                failures++;
                $display("FAIL event got kind=%0d addr=%0d data=%0h exp kind=%0d addr=%0d data=%0h",
                         got.kind, got.addr, got.data, e.kind, e.addr, e.data);
            end
        end
    endtask

    // Monitor: samples just after the falling edge, pops the scoreboard.
    initial begin
        logic              p_req, p_ack, p_we;
        logic [ADDR_W-1:0] p_addr;
        logic [7:0]        p_wdata;
        p_req = 1'b0;
        p_ack = 1'b0;
        p_we = 1'b0;
        p_addr = '0;
        p_wdata = '0;
        forever begin
            @(negedge clk);
            #1;
            if (bus_if.bs_req && p_req && !p_ack) begin
                checks++;
                if (bus_if.bs_addr != p_addr || bus_if.bs_we != p_we || bus_if.bs_wdata != p_wdata) begin
                    failures++;
                    $display("FAIL bs_hold got addr=%0d we=%0d wdata=%0h exp addr=%0d we=%0d wdata=%0h",
                             bus_if.bs_addr, bus_if.bs_we, bus_if.bs_wdata, p_addr, p_we, p_wdata);
                end
            end
            if (bus_if.ext_eep_data_wr)
                observe(mk(EV_EEP_WR, int'(bus_if.ext_load_read_eep_addr), int'(bus_if.ext_eep_data_in)));
            if (bus_if.bs_req && bus_if.bs_we && bus_if.bs_ack)
                observe(mk(EV_BS_WR, int'(bus_if.bs_addr), int'(bus_if.bs_wdata)));
            if (load_done) observe(mk(EV_LDONE, 0, 0));
            if (save_done) observe(mk(EV_SDONE, 0, 0));
            p_req   = bus_if.bs_req;
            p_ack   = bus_if.bs_ack;
            p_we    = bus_if.bs_we;
            p_addr  = bus_if.bs_addr;
            p_wdata = bus_if.bs_wdata;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        load_req = 1'b0;
        content_modifyed = 1'b0;
        randomize_store();
        core_writes_eeprom();
        repeat (3) @(negedge clk);
        chk("reset_ctrl_outputs",
            int'({busy, load_done, save_done, bus_if.ext_eep_data_en, bus_if.ext_eep_data_wr,
                  bus_if.ext_eep_data_rd, bus_if.bs_req, bus_if.bs_we}), 0);
        chk("reset_addr", int'(bus_if.ext_load_read_eep_addr), 0);
        chk("reset_data", int'({bus_if.ext_eep_data_in, bus_if.bs_wdata}), 0);

`ifdef EEP_SYNC_AUTOLOAD_EN
        expect_load();
        rst = 1'b0;
        wait_q_empty("autoload_after_reset", 100);
`else
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_after_reset", int'(busy), 0);
`endif

        // Load with same-cycle-registered store acks.
        randomize_store();
        expect_load();
        pulse_load();
        n = 0;
        while (!load_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("load_done_latency", n, 13);
        @(negedge clk);
        chk("busy_after_load", int'(busy), 0);
        wait_q_empty("load_events", 50);

        // Debounced save: two modifications five cycles apart.
        core_writes_eeprom();
        expect_save(EEP_SIZE, 1'b1);
        pulse_cm();
        repeat (4) @(negedge clk);
        pulse_cm();
        n = 0;
        while (!bus_if.ext_eep_data_rd && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("save_start_delay", n, HOLDOFF + 1);
        wait_q_empty("save_events", 200);
        repeat (HOLDOFF * 4) @(negedge clk);

        // Load request lands on the edge where the dirty flag matures.
        core_writes_eeprom();
        randomize_store();
        expect_load();
        pulse_cm();
        repeat (HOLDOFF - 1) @(negedge clk);
        pulse_load();
        wait_q_empty("priority_load", 100);
        repeat (HOLDOFF * 4) @(negedge clk);
        chk("priority_no_save", int'(busy), 0);

        // Backpressure during a save.
        ack_lat = 6;
        core_writes_eeprom();
        expect_save(EEP_SIZE, 1'b1);
        pulse_cm();
        wait_q_empty("backpressure_save", 300);
        ack_lat = $urandom_range(1, 3);

        // Reset while the third byte of a save is being read.
        core_writes_eeprom();
        expect_save(2, 1'b0);
        pulse_cm();
        wait_rd_addr("reach_byte2", 2);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outputs",
            int'({busy, bus_if.ext_eep_data_en, bus_if.bs_req, bus_if.ext_eep_data_wr,
                  bus_if.ext_eep_data_rd, save_done}), 0);
        @(negedge clk);
        #2;
        chk("abort_partial_writes", exp_q.size(), 0);
`ifdef EEP_SYNC_AUTOLOAD_EN
        expect_load();
        rst = 1'b0;
        wait_q_empty("autoload_after_abort", 100);
`else
        rst = 1'b0;
        repeat (HOLDOFF * 4) @(negedge clk);
        chk("idle_after_abort", int'(busy), 0);
`endif

        // Re-dirty during a save produces a second full save.
        ack_lat = 2;
        core_writes_eeprom();
        expect_save(EEP_SIZE, 1'b1);
        pulse_cm();
        wait_rd_addr("reach_byte1", 1);
        eep_mem[0] = ~eep_mem[0];
        expect_save(EEP_SIZE, 1'b1);
        pulse_cm();
        wait_q_empty("double_save", 400);
        repeat (HOLDOFF * 4) @(negedge clk);
        chk("quiet_at_end", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
